// File: rtl/ifetch_line_responder_pkg.sv
// Shared constants and state encoding for the instruction-fetch line responder.
// Optional performance counters are enabled by defining IFETCH_RESP_PERF_EN.
package ifetch_line_responder_pkg;

  localparam int ICACHE_LINE_BITS   = 256;
  localparam int ICACHE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } ifetch_resp_state_t;

endpackage

// File: rtl/ifetch_line_responder_array.sv
// Direct-mapped line store: combinational read by index, one synchronous refill
// write port, valid bits cleared synchronously on rst.
module icache_line_array
  import ifetch_line_responder_pkg::*;
#(
  parameter int SETS      = 16,
  parameter int IDX       = 4,
  parameter int TAG_W     = 23,
  parameter int LINE_BITS = ICACHE_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX-1:0]       rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 we,
  input  logic [IDX-1:0]       wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_line
);

  logic [SETS-1:0]      valid_q;
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/ifetch_line_responder.sv
// Read-only direct-mapped instruction cache answering fetch's ufp_* reads and
// refilling 256-bit lines over dfp_*. Counters exist only with IFETCH_RESP_PERF_EN.
module ifetch_line_responder
  import ifetch_line_responder_pkg::*;
#(
  parameter int SETS      = 16,
  parameter int LINE_BITS = ICACHE_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ufp_addr,
  input  logic [3:0]           ufp_rmask,
  output logic [31:0]          ufp_rdata,
  output logic                 ufp_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 32 - ICACHE_OFFSET_BITS - IDX;

  // Handshake: a request is any cycle with ufp_rmask != 0 while idle or while
  // a hit is being answered; ufp_resp is a single-cycle pulse for the captured
  // request; dfp_read rises with a stable dfp_addr and stays up until dfp_resp.

  ifetch_resp_state_t   state;
  logic [29:0]          req_word;
  logic                 refill_q;
  logic [LINE_BITS-1:0] refill_line;

  logic                 new_req;
  logic                 hit;
  logic [2:0]           req_off;
  logic [IDX-1:0]       req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 array_we;
  logic                 unused_byte_bits;

  assign unused_byte_bits = ^ufp_addr[1:0];

  assign new_req = |ufp_rmask;
  assign req_off = req_word[2:0];
  assign req_idx = req_word[3 +: IDX];
  assign req_tag = req_word[29 -: TAG_W];

  assign hit      = (state == LOOKUP) && rd_valid && (rd_tag == req_tag);
  assign ufp_resp = hit;
  assign ufp_rdata = hit ? rd_line[{req_off, 5'b0} +: 32] : 32'd0;

  // The refill beat is staged one cycle before it reaches the array, so the
  // replayed lookup lands two cycles after dfp_resp.
  assign array_we = (state == MISS) && refill_q;

  icache_line_array #(
    .SETS      (SETS),
    .IDX       (IDX),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (array_we),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_line  (refill_line)
  );

  always_ff @(posedge clk) begin
    if (dfp_read && dfp_resp) begin
      refill_line <= dfp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_word <= '0;
      dfp_read <= 1'b0;
      dfp_addr <= '0;
      refill_q <= 1'b0;
    end else begin
      refill_q <= dfp_read && dfp_resp;
      case (state)
        IDLE: begin
          if (new_req) begin
            req_word <= ufp_addr[31:2];
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (new_req) begin
              req_word <= ufp_addr[31:2];
            end else begin
              state <= IDLE;
            end
          end else begin
            state    <= MISS;
            dfp_read <= 1'b1;
            dfp_addr <= {req_tag, req_idx, 5'b0};
          end
        end
        MISS: begin
          if (dfp_resp) begin
            dfp_read <= 1'b0;
          end
          if (refill_q) begin
            state <= LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_RESP_PERF_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit) begin
        hit_q <= hit_q + 32'd1;
      end
      if ((state == LOOKUP) && !hit) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
